// File: rtl/fadd_arbiter.sv
// rtl/fadd_arbiter.sv - two-requester round-robin front end for a shared fixed-latency float adder
module fadd_arbiter #(
    parameter int N    = 32,
    parameter int LAT  = 3,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [N-1:0]    req0_a,
    input  logic [N-1:0]    req0_b,
    input  logic            req0_sub,
    input  logic [TAGW-1:0] req0_tag,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [N-1:0]    req1_a,
    input  logic [N-1:0]    req1_b,
    input  logic            req1_sub,
    input  logic [TAGW-1:0] req1_tag,
    output logic            add_valid,
    output logic [N-1:0]    add_a,
    output logic [N-1:0]    add_b,
    output logic            add_sub,
    input  logic [N-1:0]    add_result,
    output logic            rsp0_valid,
    output logic [N-1:0]    rsp0_data,
    output logic [TAGW-1:0] rsp0_tag,
    output logic            rsp1_valid,
    output logic [N-1:0]    rsp1_data,
    output logic [TAGW-1:0] rsp1_tag,
    output logic [3:0]      inflight
);

    logic            ptr;
    logic            grant0;
    logic            grant1;
    logic            hs;
    logic            rsp_any;
    logic [LAT-1:0]  pipe_v;
    logic [LAT-1:0]  pipe_id;
    logic [TAGW-1:0] pipe_tag [LAT];
    logic [3:0]      inflight_q;

    // ptr=1 means requester 1 wins a tie; a lone requester always wins
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && !flush) begin
            if (req0_valid && (!req1_valid || !ptr))
                grant0 = 1'b1;
            else if (req1_valid)
                grant1 = 1'b1;
        end
    end

    assign hs         = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        add_valid = hs;
        add_a     = '0;
        add_b     = '0;
        add_sub   = 1'b0;
        if (grant0) begin
            add_a   = req0_a;
            add_b   = req0_b;
            add_sub = req0_sub;
        end else if (grant1) begin
            add_a   = req1_a;
            add_b   = req1_b;
            add_sub = req1_sub;
        end
    end

    // The tail entry lines up with add_result; it still drains during a flush cycle
    assign rsp_any    = !rst && pipe_v[LAT-1];
    assign rsp0_valid = rsp_any && !pipe_id[LAT-1];
    assign rsp1_valid = rsp_any && pipe_id[LAT-1];
    assign rsp0_data  = rsp0_valid ? add_result : '0;
    assign rsp0_tag   = rsp0_valid ? pipe_tag[LAT-1] : '0;
    assign rsp1_data  = rsp1_valid ? add_result : '0;
    assign rsp1_tag   = rsp1_valid ? pipe_tag[LAT-1] : '0;
    assign inflight   = inflight_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= 1'b0;
            pipe_v     <= '0;
            pipe_id    <= '0;
            inflight_q <= 4'd0;
            for (int i = 0; i < LAT; i++)
                pipe_tag[i] <= '0;
        end else begin
            if (grant0)
                ptr <= 1'b1;
            else if (grant1)
                ptr <= 1'b0;

            for (int i = LAT - 1; i > 0; i--) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_id[i]  <= pipe_id[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
            pipe_v[0]   <= hs;
            pipe_id[0]  <= grant1;
            pipe_tag[0] <= grant1 ? req1_tag : req0_tag;

            if (flush) begin
                pipe_v     <= '0;
                inflight_q <= 4'd0;
            end else begin
                inflight_q <= inflight_q + {3'b000, hs} - {3'b000, rsp_any};
            end
        end
    end

endmodule

// File: tb/tb_fadd_arbiter.sv
// tb/tb_fadd_arbiter.sv - self-checking bench for fadd_arbiter with a float adder model and response scoreboard
module tb_fadd_arbiter;
    localparam int N    = 32;
    localparam int LAT  = 3;
    localparam int TAGW = 4;

    logic            clk = 1'b0;
    logic            rst, flush;
    logic            req0_valid, req0_ready, req0_sub;
    logic            req1_valid, req1_ready, req1_sub;
    logic [N-1:0]    req0_a, req0_b, req1_a, req1_b;
    logic [TAGW-1:0] req0_tag, req1_tag;
    logic            add_valid, add_sub;
    logic [N-1:0]    add_a, add_b, add_result;
    logic            rsp0_valid, rsp1_valid;
    logic [N-1:0]    rsp0_data, rsp1_data;
    logic [TAGW-1:0] rsp0_tag, rsp1_tag;
    logic [3:0]      inflight;

    always #5 clk = ~clk;

    fadd_arbiter #(.N(N), .LAT(LAT), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sub(req0_sub), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sub(req1_sub), .req1_tag(req1_tag),
        .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
        .add_result(add_result),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_tag(rsp1_tag),
        .inflight(inflight)
    );

    // Single-precision add through double-precision reals (normal operands only)
    function automatic real s2r(logic [31:0] s);
        logic [10:0] e;
        if (s[30:0] == 31'd0) return 0.0;
        e = {3'b000, s[30:23]} + 11'd896;
        return $bitstoreal({s[31], e, s[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2s(real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b, logic sub);
        real r;
        r = sub ? (s2r(a) - s2r(b)) : (s2r(a) + s2r(b));
        return r2s(r);
    endfunction

    function automatic logic [31:0] rfloat();
        logic [31:0] m;
        m = $urandom;
        return {m[31], 8'd120 + 8'($urandom_range(0, 14)), m[22:0]};
    endfunction

    // Shared adder: result appears LAT cycles after the issue strobe
    logic [31:0] adl [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) adl[i] <= adl[i-1];
        adl[0] <= add_valid ? fadd(add_a, add_b, add_sub) : 32'h0;
    end
    assign add_result = adl[LAT-1];

    typedef struct {
        int          due;
        int          port;
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   pref   = 0;
    int   g;
    logic dlv;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic rnd_ops();
        req0_a = rfloat(); req0_b = rfloat(); req0_sub = 1'($urandom); req0_tag = 4'($urandom);
        req1_a = rfloat(); req1_b = rfloat(); req1_sub = 1'($urandom); req1_tag = 4'($urandom);
    endtask

    // Compare every output against the scoreboard for the current cycle
    task automatic eval();
        exp_t h;
        #1;
        g = -1;
        if (!rst && !flush) begin
            if (req0_valid && req1_valid) g = pref;
            else if (req0_valid) g = 0;
            else if (req1_valid) g = 1;
        end
        h = '{due: -1, port: 0, tag: 4'd0, data: 32'd0};
        if (q.size() > 0) h = q[0];
        dlv = !rst && (q.size() > 0) && (h.due == cyc);
        chk("req0_ready", req0_ready, g == 0);
        chk("req1_ready", req1_ready, g == 1);
        chk("add_valid", add_valid, g >= 0);
        chk("add_a", add_a, g == 0 ? req0_a : g == 1 ? req1_a : 32'd0);
        chk("add_b", add_b, g == 0 ? req0_b : g == 1 ? req1_b : 32'd0);
        chk("add_sub", add_sub, g == 0 ? req0_sub : g == 1 ? req1_sub : 1'b0);
        chk("rsp0_valid", rsp0_valid, dlv && h.port == 0);
        chk("rsp0_data", rsp0_data, (dlv && h.port == 0) ? h.data : 32'd0);
        chk("rsp0_tag", rsp0_tag, (dlv && h.port == 0) ? h.tag : 4'd0);
        chk("rsp1_valid", rsp1_valid, dlv && h.port == 1);
        chk("rsp1_data", rsp1_data, (dlv && h.port == 1) ? h.data : 32'd0);
        chk("rsp1_tag", rsp1_tag, (dlv && h.port == 1) ? h.tag : 4'd0);
        chk("inflight", inflight, q.size());
    endtask

    task automatic adv();
        if (rst) begin
            q.delete();
            pref = 0;
        end else begin
            if (dlv) void'(q.pop_front());
            if (flush) q.delete();
            if (g == 0) q.push_back('{due: cyc + LAT, port: 0, tag: req0_tag, data: fadd(req0_a, req0_b, req0_sub)});
            if (g == 1) q.push_back('{due: cyc + LAT, port: 1, tag: req1_tag, data: fadd(req1_a, req1_b, req1_sub)});
            if (g >= 0) pref = 1 - g;
        end
        cyc++;
        @(negedge clk);
    endtask

    typedef struct {
        logic v0, v1, r0, r1, rv0, rv1;
    } vec_t;
    vec_t tbl [16];

    initial begin
        tbl[0]  = '{0,1, 0,1, 0,0};
        tbl[1]  = '{1,1, 1,0, 0,0};
        tbl[2]  = '{1,1, 0,1, 0,0};
        tbl[3]  = '{1,1, 1,0, 0,1};
        tbl[4]  = '{1,1, 0,1, 1,0};
        tbl[5]  = '{1,1, 1,0, 0,1};
        tbl[6]  = '{1,1, 0,1, 1,0};
        tbl[7]  = '{0,0, 0,0, 0,1};
        tbl[8]  = '{0,0, 0,0, 1,0};
        tbl[9]  = '{0,0, 0,0, 0,1};
        tbl[10] = '{0,1, 0,1, 0,0};
        tbl[11] = '{0,1, 0,1, 0,0};
        tbl[12] = '{1,1, 1,0, 0,0};
        tbl[13] = '{0,0, 0,0, 0,1};
        tbl[14] = '{0,0, 0,0, 0,1};
        tbl[15] = '{0,0, 0,0, 1,0};

        rst = 1'b1; flush = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        rnd_ops();
        repeat (LAT + 2) @(negedge clk);

        // Reset state
        eval();
        chk("reset_ready0", req0_ready, 1'b0);
        chk("reset_add_valid", add_valid, 1'b0);
        chk("reset_inflight", inflight, 4'd0);
        adv();
        rst = 1'b0;

        // Single op 1.0 + 2.0
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_sub = 1'b0; req0_tag = 4'h5;
        eval();
        chk("single_ready", req0_ready, 1'b1);
        chk("single_add_valid", add_valid, 1'b1);
        adv();
        req0_valid = 1'b0;
        repeat (LAT - 1) begin
            eval();
            chk("single_early_rsp", rsp0_valid, 1'b0);
            adv();
        end
        eval();
        chk("single_rsp_valid", rsp0_valid, 1'b1);
        chk("single_rsp_data", rsp0_data, 32'h40400000);
        chk("single_rsp_tag", rsp0_tag, 4'h5);
        chk("single_rsp1_quiet", rsp1_valid, 1'b0);
        adv();

        // Contention, drain and pointer hold
        for (int i = 0; i < 16; i++) begin
            rnd_ops();
            req0_valid = tbl[i].v0;
            req1_valid = tbl[i].v1;
            eval();
            chk($sformatf("tbl%0d_r0", i), req0_ready, tbl[i].r0);
            chk($sformatf("tbl%0d_r1", i), req1_ready, tbl[i].r1);
            chk($sformatf("tbl%0d_rv0", i), rsp0_valid, tbl[i].rv0);
            chk($sformatf("tbl%0d_rv1", i), rsp1_valid, tbl[i].rv1);
            adv();
        end

        // Flush: op issued LAT cycles earlier still drains, later ops vanish
        rnd_ops();
        req0_valid = 1'b0; req1_valid = 1'b1; req1_tag = 4'h7; eval(); adv();
        req0_valid = 1'b1; req1_valid = 1'b0; req0_tag = 4'h1; eval(); adv();
        req0_valid = 1'b0; req1_valid = 1'b1; req1_tag = 4'h2; eval(); adv();
        flush = 1'b1; req0_valid = 1'b1; req1_valid = 1'b0; req0_tag = 4'h3;
        eval();
        chk("flush_ready0", req0_ready, 1'b0);
        chk("flush_add_valid", add_valid, 1'b0);
        chk("flush_exit_valid", rsp1_valid, 1'b1);
        chk("flush_exit_tag", rsp1_tag, 4'h7);
        adv();
        flush = 1'b0; req0_valid = 1'b0;
        eval();
        chk("flush_inflight", inflight, 4'd0);
        adv();
        repeat (4) begin
            eval();
            chk("flush_no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
            adv();
        end

        // Reset mid-stream with three ops in flight
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (3) begin rnd_ops(); eval(); adv(); end
        rst = 1'b1;
        eval();
        chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
        chk("rst_add", {add_valid, add_a}, 33'd0);
        chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_data, rsp1_data}, 66'd0);
        adv();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        eval();
        chk("rst_inflight", inflight, 4'd0);
        adv();
        repeat (7) begin
            eval();
            chk("rst_no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
            adv();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        eval();
        chk("rst_ptr_grant", {req0_ready, req1_ready}, 2'b10);
        adv();

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            rnd_ops();
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            rst        = ($urandom_range(0, 39) == 0);
            eval();
            adv();
        end
        rst = 1'b0; flush = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (LAT + 2) begin eval(); adv(); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
